sync_frame_tx: RTL and testbench
================================

// Module: sync_frame_tx
// PURPOSE
//  Serial frame transmitter that drives the line feeding the team's serial sequence detectors.
//  Accepts a parallel word over valid/ready, emits sync pattern then data MSB-first (opt. parity) on sout.
//  Each bit is held CLKS_PER_BIT clocks; line idles low so idle never aliases the sync pattern.
// PARAMETERS
//  DATA_W       8       payload width, >=1
//  SYNC_W       3       sync pattern width, >=1
//  SYNC_PAT     3'b101  sync bits, sent SYNC_PAT[SYNC_W-1] first
//  CLKS_PER_BIT 1       clocks per serial bit, >=1; counter width $clog2(CLKS_PER_BIT+1)
// PORTS
//  clk          in   1       clock, all logic on posedge
//  rst          in   1       synchronous, active-high reset
//  in_valid     in   1       in_data valid
//  in_data      in   DATA_W  word to send; sampled only on accept
//  in_ready     out  1       block can accept (state IDLE and !rst)
//  sout         out  1       serial line, registered
//  bit_strobe   out  1       1-cycle pulse on first clock of every transmitted bit
//  busy         out  1       high while a frame is on the line (state != IDLE)
//  frame_done   out  1       1-cycle pulse on last clock of last bit of frame
// BEHAVIOUR
//  Reset: state=IDLE, sout=0, bit_strobe=0, busy=0, frame_done=0, counters=0; in_ready=0 while rst=1.
//  Accept: in_valid && in_ready at posedge k -> in_data latched to shift reg; first sync bit on sout
//   in cycles k+1..k+CLKS_PER_BIT, bit_strobe=1 in k+1. in_data ignored at all other times.
//  FSM: IDLE -accept-> SYNC -SYNC_W bits-> DATA -DATA_W bits-> PAR (PARITY_EN only) -> IDLE.
//   Bit advance when clock counter reaches CLKS_PER_BIT-1; counter reloads 0 at each bit start.
//   SYNC: bit index SYNC_W-1 down to 0. DATA: shift reg MSB out, shift left 1 per bit.
//  Frame length F = SYNC_W + DATA_W (+1 with PARITY_EN) bits = F*CLKS_PER_BIT clocks.
//  frame_done asserts in last clock of last bit; next cycle state=IDLE, sout=0, in_ready=1.
//  Back-to-back: in_ready low during frame, so min one idle clock (sout=0) between frames;
//   in_valid held high -> next frame accepted in that idle clock.
//  IDLE: sout=0, bit_strobe=0, busy=0.
//  rst mid-frame: abort immediately, next cycle sout=0, busy=0, no frame_done, latched word dropped.
//  CLKS_PER_BIT=1: bit_strobe high every busy clock.
// CONFIGURATION
//  PARITY_EN defined: after last data bit, one extra bit = even parity (^ of latched word), held
//   CLKS_PER_BIT clocks; frame_done moves to that bit's last clock.
//  PARITY_EN undefined: no PAR state; DATA goes directly to IDLE; F = SYNC_W + DATA_W.
// TESTING (defaults unless stated)
//  1 rst 2 clks, release -> sout=0, busy=0, in_ready=1, no strobes.
//  2 accept 8'hA5, no PARITY_EN -> sout 1,0,1,1,0,1,0,0,1,0,1 on 11 clocks, frame_done on 11th, then idle 0.
//  3 PARITY_EN: 8'hA5 -> 12th bit 0; 8'h07 -> 12th bit 1; frame_done on 12th bit.
//  4 CLKS_PER_BIT=3, 8'h80 -> each bit held 3 clocks, bit_strobe every 3rd clock, 33 busy clocks.
//  5 in_valid held high, words 8'hFF then 8'h00 -> frames separated by exactly 1 idle clock, sout=0.
//  6 rst at 4th data bit; also in_data changed mid-frame -> sout=0 next clk, no frame_done; change ignored.

Source files
------------

// File: rtl/sync_frame_tx.sv
// sync_frame_tx: serial frame transmitter, sync pattern then data MSB-first on an idle-low line.
// Define PARITY_EN to append an even-parity bit after the data.
module sync_frame_tx #(
  parameter int                DATA_W       = 8,
  parameter int                SYNC_W       = 3,
  parameter logic [SYNC_W-1:0] SYNC_PAT     = 3'b101,
  parameter int                CLKS_PER_BIT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              sout,
  output logic              bit_strobe,
  output logic              busy,
  output logic              frame_done
);
  localparam int FW = SYNC_W + DATA_W;
`ifdef PARITY_EN
  localparam int F = FW + 1;
`else
  localparam int F = FW;
`endif
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int BW = $clog2(F + 1);
  typedef enum logic [1:0] {IDLE, SYNC, DATA, PAR} state_t;
  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [BW-1:0]   r_bit;
  logic [FW-1:0]   r_shift;
`ifdef PARITY_EN
  logic            r_par;
`endif
  logic            w_adv;
  logic            w_last;
  logic            w_next_last;
  logic [BW-1:0]   w_nbit;
  logic [FW-1:0]   w_frame;
  // Sync pattern and payload share one shift register so every bit leaves from its MSB.
  assign w_frame     = {SYNC_PAT, in_data};
  assign w_adv       = r_cnt == CW'(CLKS_PER_BIT - 1);
  assign w_last      = r_bit == BW'(F - 1);
  assign w_next_last = r_bit == BW'(F - 2);
  assign w_nbit      = r_bit + 1'b1;
  assign in_ready    = r_state == IDLE && !rst;
  assign busy        = r_state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_bit      <= '0;
      r_shift    <= '0;
      sout       <= 1'b0;
      bit_strobe <= 1'b0;
      frame_done <= 1'b0;
`ifdef PARITY_EN
      r_par      <= 1'b0;
`endif
    end else if (r_state == IDLE) begin
      r_cnt      <= '0;
      r_bit      <= '0;
      bit_strobe <= in_valid;
      frame_done <= 1'b0;
      sout       <= in_valid & w_frame[FW-1];
      if (in_valid) begin
        r_state <= SYNC;
        r_shift <= w_frame << 1;
`ifdef PARITY_EN
        r_par   <= ^in_data;
`endif
      end
    end else if (!w_adv) begin
      r_cnt      <= r_cnt + 1'b1;
      bit_strobe <= 1'b0;
      frame_done <= w_last && r_cnt + 1'b1 == CW'(CLKS_PER_BIT - 1);
    end else if (w_last) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      sout       <= 1'b0;
      bit_strobe <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      r_cnt      <= '0;
      r_bit      <= w_nbit;
      r_shift    <= r_shift << 1;
      bit_strobe <= 1'b1;
      frame_done <= w_next_last && CLKS_PER_BIT == 1;
`ifdef PARITY_EN
      sout       <= w_nbit == BW'(FW) ? r_par : r_shift[FW-1];
      r_state    <= w_nbit == BW'(FW) ? PAR : w_nbit < BW'(SYNC_W) ? SYNC : DATA;
`else
      sout       <= r_shift[FW-1];
      r_state    <= w_nbit < BW'(SYNC_W) ? SYNC : DATA;
`endif
    end
  end
endmodule

// File: tb/tb_sync_frame_tx.sv
// tb_sync_frame_tx: two transmitters (1 and 3 clocks per bit) under random words, gaps and resets,
// each line checked cycle by cycle against a queue of expected frame bits.
module tb_sync_frame_tx;
  logic clk = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [7:0] dir [5] = '{8'hA5, 8'h07, 8'hFF, 8'h00, 8'h80};
`ifdef PARITY_EN
  localparam bit PE = 1'b1;
`else
  localparam bit PE = 1'b0;
`endif
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL u%0d %s: got %0h expected %0h", g, nm, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int CPB = g == 0 ? 1 : 3;
    logic rst = 1'b1, valid = 1'b0, rst_q = 1'b1;
    logic [7:0] data = 8'h00;
    logic in_ready, sout, bit_strobe, busy, frame_done;
    int   q[$];
    int   rem = 0, acc_cnt = 0, fv = 0, e = 0;
    bit   m_idle = 1'b0, exp_busy = 1'b0, start = 1'b0, cur = 1'b0, last = 1'b0, fin = 1'b0;

    sync_frame_tx #(.DATA_W(8), .SYNC_W(3), .SYNC_PAT(3'b101), .CLKS_PER_BIT(CPB)) dut (
      .clk(clk), .rst(rst), .in_valid(valid), .in_data(data), .in_ready(in_ready),
      .sout(sout), .bit_strobe(bit_strobe), .busy(busy), .frame_done(frame_done));

    always @(posedge clk) rst_q <= rst;

    // Reference: an accepted word becomes the frame 101,d7..d0[,parity]; reset drops everything.
    always @(posedge clk) begin
      if (rst) q.delete();
      else if (valid && m_idle) begin
        fv = (5 << 8) | int'(data);
        for (int b = 10; b >= 0; b--) q.push_back(((fv >> b) & 1) | ((b == 0 && !PE) ? 2 : 0));
        if (PE) q.push_back(($countones(data) % 2) | 2);
        acc_cnt++;
      end
    end

    always @(negedge clk) begin
      if (rst_q) rem = 0;
      exp_busy = rem > 0 || q.size() > 0;
      start = 1'b0;
      if (rem == 0 && q.size() > 0) begin
        e = q.pop_front();
        cur = e[0];
        last = e[1];
        rem = CPB;
        start = 1'b1;
      end
      chk("busy", g, 32'(busy), 32'(exp_busy));
      chk("sout", g, 32'(sout), 32'(exp_busy & cur));
      chk("bit_strobe", g, 32'(bit_strobe), 32'(start));
      chk("frame_done", g, 32'(frame_done), 32'(exp_busy && last && rem == 1));
      chk("in_ready", g, 32'(in_ready), 32'(!rst && !exp_busy));
      if (rem > 0) rem--;
      m_idle = !exp_busy;
    end

    initial begin
      int a0, t;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      for (int n = 0; n < 30; n++) begin
        if (n >= 5 && $urandom_range(0, 2) == 0) begin
          valid = 1'b0;
          repeat ($urandom_range(1, 15 * CPB)) @(posedge clk);
          #1;
        end
        data = n < 5 ? dir[n] : 8'($urandom);
        valid = 1'b1;
        a0 = acc_cnt;
        t = 0;
        while (acc_cnt == a0 && t < 200) begin
          @(posedge clk);
          #1;
          t++;
        end
        chk("accept_wait", g, 32'(acc_cnt != a0), 32'd1);
        data = 8'($urandom);
        if (n == 6 || n == 17) begin
          valid = 1'b0;
          repeat (6 * CPB) @(posedge clk);
          #1 rst = 1'b1;
          @(posedge clk);
          #1 rst = 1'b0;
        end
      end
      valid = 1'b0;
      repeat (40 * CPB) @(posedge clk);
      fin = 1'b1;
    end
  end

  initial begin
    for (int t = 0; t < 40000 && !(u[0].fin && u[1].fin); t++) @(posedge clk);
    if (!(u[0].fin && u[1].fin)) begin
      n_cmp++;
      n_err++;
      $display("FAIL run_timeout: got unfinished expected finished");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
